// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the five-stage MIPS pipeline.
// Word loads/stores against a local data memory with a multi-cycle access
// latency, an upstream stall while the access is in flight, and the MEM/WB
// pipeline register that feeds write-back.
module mem_stage #(
   parameter int DEPTH_WORDS = 256,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [1:0]  ctlwb_in,
   input  logic [1:0]  ctlm_in,
   input  logic [31:0] alu_result_in,
   input  logic [31:0] rdata2_in,
   input  logic [4:0]  muxout_in,
   output logic        stall,
   output logic        valid_out,
   output logic [1:0]  ctlwb_out,
   output logic [31:0] read_data_out,
   output logic [31:0] alu_result_out,
   output logic [4:0]  muxout_out,
   output logic        fault_out
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(MEM_LATENCY) + 1;
   // cnt value on the cycle the access completes and is accepted
   localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [CW-1:0] cnt;
   logic          mem_read, mem_write, memop, aligned, access;
   logic [AW-1:0] idx;

   assign mem_read  = ctlm_in[1];
   assign mem_write = ctlm_in[0];
   assign memop     = valid_in & (mem_read | mem_write);
   assign aligned   = (alu_result_in[1:0] == 2'b00);
   // upper address bits are dropped so out-of-range addresses wrap
   assign idx       = alu_result_in[AW+1:2];
   assign access    = memop & aligned;

   // Hold upstream until the access has been pending MEM_LATENCY-1 cycles
   always_comb begin
      stall = !rst && access && (cnt != LAST);
   end

   // Wait counter and MEM/WB register; a stall cycle inserts a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         valid_out      <= 1'b0;
         ctlwb_out      <= 2'b00;
         read_data_out  <= '0;
         alu_result_out <= '0;
         muxout_out     <= '0;
         fault_out      <= 1'b0;
      end else if (stall) begin
         cnt       <= cnt + CW'(1);
         valid_out <= 1'b0;
         ctlwb_out <= 2'b00;
         fault_out <= 1'b0;
      end else begin
         cnt            <= '0;
         valid_out      <= valid_in;
         // misaligned memops must not write back
         ctlwb_out      <= (valid_in && !(memop && !aligned)) ? ctlwb_in : 2'b00;
         alu_result_out <= alu_result_in;
         muxout_out     <= muxout_in;
         fault_out      <= memop & !aligned;
         // nonblocking read returns the word before any same-edge store
         if (access && mem_read)
            read_data_out <= mem[idx];
      end
   end

   // Data memory write, only on the edge that accepts the store
   always_ff @(posedge clk) begin
      if (!rst && !stall && access && mem_write)
         mem[idx] <= rdata2_in;
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage at latencies 1, 2 and 4.
// All three instances share the same input drive; each test checks the
// instance whose latency the scenario targets.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [1:0]  ctlwb_in, ctlm_in;
   logic [31:0] alu_result_in, rdata2_in;
   logic [4:0]  muxout_in;

   logic        stall2, valid2, fault2;
   logic [1:0]  wb2;
   logic [31:0] rd2, alu2;
   logic [4:0]  mux2;
   logic        stall4, valid4, fault4;
   logic [1:0]  wb4;
   logic [31:0] rd4, alu4;
   logic [4:0]  mux4;
   logic        stall1, valid1, fault1;
   logic [1:0]  wb1;
   logic [31:0] rd1, alu1;
   logic [4:0]  mux1;

   int checks = 0;
   int passed = 0;
   logic saw_stall1 = 1'b0;

   always #5 clk = ~clk;

   mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
      .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
      .stall(stall2), .valid_out(valid2), .ctlwb_out(wb2), .read_data_out(rd2),
      .alu_result_out(alu2), .muxout_out(mux2), .fault_out(fault2));

   mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
      .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
      .stall(stall4), .valid_out(valid4), .ctlwb_out(wb4), .read_data_out(rd4),
      .alu_result_out(alu4), .muxout_out(mux4), .fault_out(fault4));

   mem_stage #(.DEPTH_WORDS(256), .MEM_LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
      .alu_result_in(alu_result_in), .rdata2_in(rdata2_in), .muxout_in(muxout_in),
      .stall(stall1), .valid_out(valid1), .ctlwb_out(wb1), .read_data_out(rd1),
      .alu_result_out(alu1), .muxout_out(mux1), .fault_out(fault1));

   // latency-1 instance must never stall
   always @(negedge clk) if (stall1 === 1'b1) saw_stall1 = 1'b1;

   task automatic drive(input logic v, input logic [1:0] wb, input logic [1:0] m,
                        input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
      valid_in = v; ctlwb_in = wb; ctlm_in = m;
      alu_result_in = a; rdata2_in = d; muxout_in = r;
      #1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      drive(1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b1, 2'b11, 2'b11, 32'h40, 32'hFFFF_FFFF, 5'd7);
      checks++; if (stall2 !== 1'b0) $display("FAIL reset_stall_pre got %b want 0", stall2); else passed++;
      step;
      checks++; if (stall2 !== 1'b0) $display("FAIL reset_stall got %b want 0", stall2); else passed++;
      checks++; if ({valid2, wb2, fault2} !== 4'b0) $display("FAIL reset_ctl got %b want 0000", {valid2, wb2, fault2}); else passed++;
      checks++; if ({rd2, alu2, mux2} !== 69'h0) $display("FAIL reset_data got %h want 0", {rd2, alu2, mux2}); else passed++;
      checks++; if (u_dut2.cnt !== 2'd0) $display("FAIL reset_cnt got %0d want 0", u_dut2.cnt); else passed++;
      idle;
      rst = 1'b0;
      step;
   endtask

   task automatic test_passthrough;
      drive(1'b1, 2'b10, 2'b00, 32'h1234, 32'h0, 5'd5);
      checks++; if (stall2 !== 1'b0) $display("FAIL pass_stall got %b want 0", stall2); else passed++;
      step;
      checks++; if ({valid2, wb2, fault2} !== 4'b1100) $display("FAIL pass_ctl got %b want 1100", {valid2, wb2, fault2}); else passed++;
      checks++; if (alu2 !== 32'h1234 || mux2 !== 5'd5) $display("FAIL pass_data got %h/%0d want 1234/5", alu2, mux2); else passed++;
      idle; step;
   endtask

   task automatic test_store_load;
      drive(1'b1, 2'b00, 2'b01, 32'h10, 32'hDEAD_BEEF, 5'd0);
      checks++; if (stall2 !== 1'b1) $display("FAIL st_stall got %b want 1", stall2); else passed++;
      step;
      checks++; if (valid2 !== 1'b0 || wb2 !== 2'b00) $display("FAIL st_bubble got %b%b want 000", valid2, wb2); else passed++;
      checks++; if (stall2 !== 1'b0) $display("FAIL st_stall_end got %b want 0", stall2); else passed++;
      step;
      checks++; if (valid2 !== 1'b1) $display("FAIL st_valid got %b want 1", valid2); else passed++;
      drive(1'b1, 2'b11, 2'b10, 32'h10, 32'h0, 5'd9);
      checks++; if (stall2 !== 1'b1) $display("FAIL ld_stall got %b want 1", stall2); else passed++;
      step;
      checks++; if (valid2 !== 1'b0) $display("FAIL ld_bubble got %b want 0", valid2); else passed++;
      step;
      checks++; if (rd2 !== 32'hDEAD_BEEF) $display("FAIL ld_data got %h want deadbeef", rd2); else passed++;
      checks++; if ({valid2, wb2, mux2} !== {1'b1, 2'b11, 5'd9}) $display("FAIL ld_ctl got %b want 1119", {valid2, wb2, mux2}); else passed++;
      idle; step;
   endtask

   task automatic test_wrap;
      drive(1'b1, 2'b00, 2'b01, 32'h400, 32'hA5A5_A5A5, 5'd0);
      step; step;
      drive(1'b1, 2'b11, 2'b10, 32'h0, 32'h0, 5'd3);
      step; step;
      checks++; if (rd2 !== 32'hA5A5_A5A5) $display("FAIL wrap_data got %h want a5a5a5a5", rd2); else passed++;
      idle; step;
   endtask

   task automatic test_misaligned;
      drive(1'b1, 2'b11, 2'b10, 32'h13, 32'h0, 5'd4);
      checks++; if (stall2 !== 1'b0) $display("FAIL mis_stall got %b want 0", stall2); else passed++;
      step;
      checks++; if ({valid2, wb2, fault2} !== 4'b1001) $display("FAIL mis_ctl got %b want 1001", {valid2, wb2, fault2}); else passed++;
      checks++; if (rd2 !== 32'hA5A5_A5A5) $display("FAIL mis_data got %h want a5a5a5a5", rd2); else passed++;
      // a following non-memory op clears the fault flag
      drive(1'b1, 2'b10, 2'b00, 32'h8, 32'h0, 5'd1);
      step;
      checks++; if (fault2 !== 1'b0) $display("FAIL mis_clear got %b want 0", fault2); else passed++;
      idle; step;
   endtask

   task automatic test_back_to_back;
      // store immediately followed by a load of the same word, latency 2
      drive(1'b1, 2'b00, 2'b01, 32'h44, 32'h600D_F00D, 5'd0);
      step; step;
      drive(1'b1, 2'b11, 2'b10, 32'h44, 32'h0, 5'd2);
      checks++; if (stall2 !== 1'b1) $display("FAIL b2b_stall got %b want 1", stall2); else passed++;
      step; step;
      checks++; if (rd2 !== 32'h600D_F00D) $display("FAIL b2b_data got %h want 600df00d", rd2); else passed++;
      idle; step;
   endtask

   task automatic test_latency1;
      drive(1'b1, 2'b00, 2'b01, 32'h30, 32'hCAFE_0001, 5'd0);
      step;
      drive(1'b1, 2'b11, 2'b10, 32'h30, 32'h0, 5'd6);
      step;
      checks++; if (rd1 !== 32'hCAFE_0001 || valid1 !== 1'b1) $display("FAIL lat1_data got %h/%b want cafe0001/1", rd1, valid1); else passed++;
      idle; step;
      checks++; if (saw_stall1 !== 1'b0) $display("FAIL lat1_stall got %b want 0", saw_stall1); else passed++;
   endtask

   task automatic test_reset_mid;
      int nstall;
      // known prior contents at 0x20
      drive(1'b1, 2'b00, 2'b01, 32'h20, 32'h1111_1111, 5'd0);
      nstall = 0;
      for (int i = 0; i < 4; i++) begin
         if (stall4 === 1'b1) nstall++;
         step;
      end
      checks++; if (nstall !== 3 || valid4 !== 1'b1) $display("FAIL lat4_stall got %0d/%b want 3/1", nstall, valid4); else passed++;
      idle; step;
      // aborted store: reset in the second stall cycle
      drive(1'b1, 2'b00, 2'b01, 32'h20, 32'h55, 5'd0);
      step;
      checks++; if (stall4 !== 1'b1) $display("FAIL rm_stall got %b want 1", stall4); else passed++;
      rst = 1'b1;
      #1;
      checks++; if (stall4 !== 1'b0) $display("FAIL rm_stall_rst got %b want 0", stall4); else passed++;
      step;
      checks++; if (u_dut4.cnt !== 3'd0 || valid4 !== 1'b0 || rd4 !== 32'h0) $display("FAIL rm_state got %0d/%b/%h want 0/0/0", u_dut4.cnt, valid4, rd4); else passed++;
      idle;
      rst = 1'b0;
      step;
      drive(1'b1, 2'b11, 2'b10, 32'h20, 32'h0, 5'd8);
      for (int i = 0; i < 4; i++) step;
      checks++; if (rd4 !== 32'h1111_1111) $display("FAIL rm_data got %h want 11111111", rd4); else passed++;
      idle; step;
   endtask

   initial begin
      test_reset;
      test_passthrough;
      test_store_load;
      test_wrap;
      test_misaligned;
      test_back_to_back;
      test_latency1;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM latch outputs (WB/M control, ALU result, store data, destination register), performs word loads and stores against an internal data memory with a parameterised multi-cycle access latency, and stalls upstream while an access is in flight. It contains the MEM/WB pipeline register that feeds the write-back stage.

## Interface
Parameters:
- DEPTH_WORDS, 256, data memory size in 32-bit words; power of two, ≥ 4.
- MEM_LATENCY, 2, cycles per memory access, ≥ 1.

Ports:
- clk  in  1  pipeline clock; one clock domain, all state on rising edge.
- rst  in  1  reset; synchronous, active-high.
- valid_in  in  1  EX/MEM holds a real instruction.
- ctlwb_in  in  2  [1] RegWrite, [0] MemtoReg.
- ctlm_in  in  2  [1] MemRead, [0] MemWrite.
- alu_result_in  in  32  byte address for loads and stores; ALU result otherwise.
- rdata2_in  in  32  store data.
- muxout_in  in  5  destination register number.
- stall  out  1  combinational; upstream holds EX/MEM contents while high.
- valid_out  out  1  MEM/WB holds a real instruction.
- ctlwb_out  out  2  registered WB control.
- read_data_out  out  32  registered load data.
- alu_result_out  out  32  registered copy of alu_result_in.
- muxout_out  out  5  registered destination register.
- fault_out  out  1  registered; the MEM/WB entry is a misaligned access.

## Operation
- memop = valid_in & (MemRead | MemWrite); aligned = (alu_result_in[1:0] == 0).
- Word index = alu_result_in[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so out-of-range addresses wrap.
- Wait counter cnt, width clog2(MEM_LATENCY)+1. State is IDLE when cnt == 0 and WAIT otherwise.
- stall = !rst & memop & aligned & (cnt != MEM_LATENCY-1).
- Each edge:
  - If stall: cnt <= cnt+1. MEM/WB loads a bubble: valid_out=0, ctlwb_out=00, fault_out=0. Other outputs hold.
  - If !stall: cnt <= 0. MEM/WB captures the instruction.
- Accepted instruction with memop & aligned:
  - MemWrite: mem[index] <= rdata2_in, written only on the accepting edge.
  - MemRead: read_data_out <= mem[index], the value before any same-edge write.
- Both MemRead and MemWrite set: the write is performed and read_data_out returns the old word.
- Misaligned memop: no memory access and no stall. MEM/WB captures valid_out=1, ctlwb_out=00, fault_out=1; read_data_out holds its previous value.
- Non-memory instruction, or valid_in=0: passes in one cycle and read_data_out holds its previous value. When valid_in=0, MEM/WB captures valid_out=0, ctlwb_out=00.
- If valid_in drops or ctlm_in changes to a non-memop while cnt ≠ 0, stall deasserts and cnt returns to 0. No write is performed for the abandoned access. Upstream must not do this in normal operation.
- Memory contents are not reset and are undefined after power-up.

## Timing
- Reset, on the first edge with rst=1: cnt=0 and valid_out=0, ctlwb_out=00, read_data_out=0, alu_result_out=0, muxout_out=0, fault_out=0. stall=0 while rst is high.
- Reset mid-access: the pending store is dropped, and cnt and all outputs return to their reset values.
- Non-memory or misaligned instruction: outputs are valid 1 cycle after acceptance.
- Aligned memop: stall is high for MEM_LATENCY-1 consecutive cycles, starting the cycle the op appears. The instruction is accepted on the next edge and MEM/WB shows it one cycle after that. Total residency is MEM_LATENCY cycles.
- MEM_LATENCY=1: stall is never asserted and throughput is one instruction per cycle.
- Back-to-back memops each take MEM_LATENCY cycles. A load following a store to the same word returns the stored data.

## Test plan
- Reset: drive rst=1 for one edge with memop inputs active -> all outputs 0, stall=0, cnt=0.
- ALU passthrough (MEM_LATENCY=2): ctlwb_in=10, ctlm_in=00, alu_result_in=0x1234 -> next cycle valid_out=1, ctlwb_out=10, alu_result_out=0x1234, stall never high.
- Store then load (MEM_LATENCY=2):
  - Store: ctlm_in=01, addr 0x10, data 0xDEADBEEF -> stall for 1 cycle, bubble in MEM/WB during the stall.
  - Load: ctlm_in=10, ctlwb_in=11, addr 0x10 -> stall for 1 cycle, then read_data_out=0xDEADBEEF, ctlwb_out=11.
- Wrap (DEPTH_WORDS=256): store 0xA5A5A5A5 to address 0x400, then load address 0x0 -> read_data_out=0xA5A5A5A5.
- Misaligned: load at address 0x13 -> no stall, valid_out=1, fault_out=1, ctlwb_out=00, read_data_out unchanged.
- Reset mid-access (MEM_LATENCY=4): start a store of 0x55 to 0x20 and assert rst in the second stall cycle. A later load from 0x20 must return the prior contents, not 0x55.
